// File: rtl/rsa_pkg.sv
// Shared widths, constants and state encoding for the RSA key generator.
package rsa_pkg;

  localparam int OP_W  = 8;
  localparam int PHI_W = 16;

  localparam logic [OP_W-1:0] E_MIN = 8'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PHI   = 3'd1,
    S_REM   = 3'd2,
    S_GCD   = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } keygen_state_t;

endpackage

// File: rtl/key_gen_if.sv
// Request/result bundle between the key generator and its requester.
interface key_gen_if;
  import rsa_pkg::*;

  logic            start;
  logic [OP_W-1:0] p;
  logic [OP_W-1:0] q;
  logic [OP_W-1:0] e;
  logic            finish;

  modport master (output start, output p, output q, input e, input finish);
  modport slave  (input start, input p, input q, output e, output finish);

endinterface

// File: rtl/mod_div16.sv
// 16-by-8 restoring remainder unit: one quotient bit per cycle, MSB first,
// done asserted during the 16th step with the final remainder on rem_o.
module mod_div16
  import rsa_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [PHI_W-1:0] dividend_i,
  input  logic [OP_W-1:0]  divisor_i,
  output logic             done_o,
  output logic [OP_W-1:0]  rem_o
);

  logic             busy_q, busy_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [PHI_W-1:0] dvd_q, dvd_d;
  logic [OP_W-1:0]  dvs_q, dvs_d;
  logic [OP_W-1:0]  rem_q, rem_d;
  logic [OP_W:0]    shift_s;
  logic [OP_W-1:0]  rem_step_s;

  // One restoring step; the partial remainder stays below the divisor,
  // so the low 8 bits of the difference are exact.
  always_comb begin
    shift_s = {rem_q, dvd_q[PHI_W-1]};
    if (shift_s >= {1'b0, dvs_q}) begin
      rem_step_s = shift_s[OP_W-1:0] - dvs_q;
    end else begin
      rem_step_s = shift_s[OP_W-1:0];
    end
  end

  assign done_o = busy_q && (cnt_q == 4'd15);
  assign rem_o  = rem_step_s;

  // Load on start, otherwise iterate while busy.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = 4'd0;
      dvd_d  = dividend_i;
      dvs_d  = divisor_i;
      rem_d  = 8'd0;
    end else if (busy_q) begin
      rem_d = rem_step_s;
      dvd_d = {dvd_q[PHI_W-2:0], 1'b0};
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd15) begin
        busy_d = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= 4'd0;
      dvd_q  <= 16'd0;
      dvs_q  <= 8'd0;
      rem_q  <= 8'd0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
    end
  end

endmodule

// File: rtl/key_gen.sv
// RSA public-exponent search: smallest e >= 3, e < phi, gcd(e, phi) = 1,
// using a serial remainder unit and a subtraction Euclid loop.
module key_gen
  import rsa_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  key_gen_if.slave  bus
);

  keygen_state_t    state_q, state_d;
  logic [OP_W-1:0]  p_q, p_d, q_q, q_d;
  logic [PHI_W-1:0] phi_q, phi_d;
  logic [OP_W-1:0]  c_q, c_d;
  logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]  e_q, e_d;
  logic             finish_q, finish_d;

  logic [OP_W-1:0]  pm1_s, qm1_s;
  logic [PHI_W-1:0] prod_s;
  logic [OP_W:0]    c_inc_s;
  logic [OP_W-1:0]  a_step_s, b_step_s;
  logic             div_start_s, div_done_s;
  logic [PHI_W-1:0] div_dvd_s;
  logic [OP_W-1:0]  div_dvs_s, div_rem_s;

  assign pm1_s   = p_q - 8'd1;
  assign qm1_s   = q_q - 8'd1;
  assign prod_s  = {8'd0, pm1_s} * {8'd0, qm1_s};
  assign c_inc_s = {1'b0, c_q} + 9'd1;

  // One Euclid subtraction step on the current pair.
  always_comb begin
    a_step_s = a_q;
    b_step_s = b_q;
    if (a_q > b_q) begin
      a_step_s = a_q - b_q;
    end else if (b_q > a_q) begin
      b_step_s = b_q - a_q;
    end else begin
      a_step_s = a_q;
    end
  end

  // The first division is launched from PHI before phi is registered.
  always_comb begin
    if (state_q == S_PHI) begin
      div_dvd_s = prod_s;
      div_dvs_s = E_MIN;
    end else begin
      div_dvd_s = phi_q;
      div_dvs_s = c_inc_s[OP_W-1:0];
    end
  end

  mod_div16 u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start_s),
    .dividend_i (div_dvd_s),
    .divisor_i  (div_dvs_s),
    .done_o     (div_done_s),
    .rem_o      (div_rem_s)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    q_d         = q_q;
    phi_d       = phi_q;
    c_d         = c_q;
    a_d         = a_q;
    b_d         = b_q;
    e_d         = e_q;
    finish_d    = 1'b0;
    div_start_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          p_d     = bus.p;
          q_d     = bus.q;
          state_d = S_PHI;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PHI: begin
        if ((p_q < 8'd2) || (q_q < 8'd2) || (prod_s <= 16'd3)) begin
          e_d      = 8'd0;
          finish_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          phi_d       = prod_s;
          c_d         = E_MIN;
          div_start_s = 1'b1;
          state_d     = S_REM;
        end
      end
      S_REM: begin
        if (div_done_s) begin
          a_d     = c_q;
          b_d     = div_rem_s;
          state_d = S_GCD;
        end else begin
          state_d = S_REM;
        end
      end
      S_GCD: begin
        if ((a_q == b_q) || (b_q == 8'd0)) begin
          state_d = S_CHECK;
        end else begin
          a_d = a_step_s;
          b_d = b_step_s;
          if ((a_step_s == b_step_s) || (b_step_s == 8'd0)) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_GCD;
          end
        end
      end
      S_CHECK: begin
        if (a_q == 8'd1) begin
          e_d      = c_q;
          finish_d = 1'b1;
          state_d  = S_DONE;
        end else if (c_inc_s[OP_W] || ({7'd0, c_inc_s} >= phi_q)) begin
          e_d      = 8'd0;
          finish_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          c_d         = c_inc_s[OP_W-1:0];
          div_start_s = 1'b1;
          state_d     = S_REM;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and datapath registers; e/finish are loaded on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      p_q      <= 8'd0;
      q_q      <= 8'd0;
      phi_q    <= 16'd0;
      c_q      <= 8'd0;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      e_q      <= 8'd0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      q_q      <= q_d;
      phi_q    <= phi_d;
      c_q      <= c_d;
      a_q      <= a_d;
      b_q      <= b_d;
      e_q      <= e_d;
      finish_q <= finish_d;
    end
  end

  assign bus.e      = e_q;
  assign bus.finish = finish_q;

endmodule

// File: tb/tb_key_gen.sv
// Directed scoreboard bench for key_gen.
module tb_key_gen;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  int   cyc;
  logic [7:0] sb_q [$];

  key_gen_if bus ();

  key_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_start(input logic [7:0] pv, input logic [7:0] qv, input logic [7:0] ev);
    @(negedge clk);
    bus.start = 1'b1;
    bus.p     = pv;
    bus.q     = qv;
    sb_q.push_back(ev);
    @(negedge clk);
    bus.start = 1'b0;
    bus.p     = 8'd0;
    bus.q     = 8'd0;
  endtask

  task automatic pulse_start(input logic [7:0] pv, input logic [7:0] qv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.p     = pv;
    bus.q     = qv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.p     = 8'd0;
    bus.q     = 8'd0;
  endtask

  task automatic wait_finish(input string tag, output int cycles);
    logic [7:0] exp_e;
    cycles = 0;
    while ((bus.finish !== 1'b1) && (cycles < 10000)) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_finish_seen"}, {15'd0, bus.finish}, 16'd1);
    if (sb_q.size() > 0) begin
      exp_e = sb_q.pop_front();
    end else begin
      exp_e = 8'hxx;
    end
    check({tag, "_e"}, {8'd0, bus.e}, {8'd0, exp_e});
    @(negedge clk);
    check({tag, "_finish_1cyc"}, {15'd0, bus.finish}, 16'd0);
    check({tag, "_e_hold"}, {8'd0, bus.e}, {8'd0, exp_e});
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.p     = 8'd0;
    bus.q     = 8'd0;

    repeat (3) @(negedge clk);
    check("rst_e", {8'd0, bus.e}, 16'd0);
    check("rst_finish", {15'd0, bus.finish}, 16'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_e", {8'd0, bus.e}, 16'd0);
    check("idle_finish", {15'd0, bus.finish}, 16'd0);

    run_start(8'd3, 8'd5, 8'd3);
    wait_finish("p3q5", cyc);
    check("p3q5_latency_le25", {15'd0, (cyc <= 25)}, 16'd1);
    repeat (5) @(negedge clk);
    check("p3q5_e_hold_late", {8'd0, bus.e}, 16'd3);

    run_start(8'd5, 8'd7, 8'd5);
    wait_finish("p5q7", cyc);

    run_start(8'd11, 8'd13, 8'd7);
    wait_finish("p11q13", cyc);

    run_start(8'd2, 8'd3, 8'd0);
    wait_finish("p2q3", cyc);

    run_start(8'd17, 8'd19, 8'd5);
    repeat (3) @(negedge clk);
    pulse_start(8'd3, 8'd5);
    repeat (12) @(negedge clk);
    pulse_start(8'd11, 8'd13);
    wait_finish("p17q19", cyc);

    run_start(8'd1, 8'd7, 8'd0);
    wait_finish("p1q7", cyc);

    run_start(8'd11, 8'd13, 8'd7);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_e", {8'd0, bus.e}, 16'd0);
    check("midrst_finish", {15'd0, bus.finish}, 16'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("postrst_e", {8'd0, bus.e}, 16'd0);
    run_start(8'd3, 8'd5, 8'd3);
    wait_finish("after_rst_p3q5", cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
